spk_addr_serializer: RTL and testbench

Sequential, parametrised spike-address encoder. Accepts one N_IN-bit spike vector per frame through a valid/ready handshake, then emits the index of every set bit, lowest first, one address per accepted output beat. It scans CHUNK bits per cycle, reports a per-frame spike count and pulses `done` at frame end. It sits between a layer's spike register and the synaptic-weight fetch logic, replacing the single-cycle 32-bit priority encoder for wide layers.

---
 rtl/snn_pkg.sv | 11 +
 rtl/prio_enc_w.sv | 26 ++
 rtl/spk_addr_serializer.sv | 105 ++++++++++
 tb/tb_spk_addr_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions.
//   enc_state_t : spike-address encoder frame state (IDLE, SCAN, DONE)
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/prio_enc_w.sv
// Combinational lowest-set-bit encoder.
//   vec : input word
//   pos : index of the lowest set bit in vec (0 when vec is zero)
//   nz  : vec has at least one bit set
module prio_enc_w #(
  parameter int unsigned W = 32,
  localparam int unsigned POS_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [POS_W-1:0] pos,
  output logic             nz
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    pos = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        pos = POS_W'(i);
      end
    end
  end

  assign nz = |vec;

endmodule

// File: rtl/spk_addr_serializer.sv
// Sequential spike-address encoder: captures one spike vector per frame and
// emits the index of every set bit, lowest first, one per accepted beat.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : spike-vector handshake (spk_vec captured in IDLE)
//   out_valid / out_ready : address handshake; out_addr, out_last ride on it
//   busy                  : a frame is in progress
//   done                  : one-cycle pulse at frame end
//   spk_count             : addresses accepted in the current or last frame
module spk_addr_serializer
  import snn_pkg::*;
#(
  parameter int unsigned N_IN  = 256,
  parameter int unsigned CHUNK = 32,
  localparam int unsigned ADDR_W = $clog2(N_IN),
  localparam int unsigned CNT_W  = $clog2(N_IN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   spk_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  spk_count
);

  localparam int unsigned POS_W   = $clog2(CHUNK);
  localparam int unsigned N_CHUNK = N_IN / CHUNK;
  localparam int unsigned IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  enc_state_t        state;
  logic [N_IN-1:0]   wv;
  logic [IDX_W-1:0]  idx;

  logic [CHUNK-1:0]  cur_chunk;
  logic [POS_W-1:0]  pos;
  logic              nz;
  logic [N_IN-1:0]   wv_drop;
  logic              single_left;

  // Chunk under inspection; all chunks below idx are already empty.
  assign cur_chunk = CHUNK'(wv >> (32'(idx) * CHUNK));

  prio_enc_w #(.W(CHUNK)) u_prio (
    .vec (cur_chunk),
    .pos (pos),
    .nz  (nz)
  );

  // The emitted bit is the lowest set bit of the whole vector, so clearing
  // it is wv & (wv-1); a zero result also means it was the last one.
  assign wv_drop     = wv & (wv - N_IN'(1));
  assign single_left = (wv_drop == '0);

  // Frame FSM with working vector, chunk index and spike count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wv        <= '0;
      idx       <= '0;
      spk_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wv        <= spk_vec;
            idx       <= '0;
            spk_count <= '0;
            state     <= (spk_vec != '0) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (!nz) begin
            idx <= idx + IDX_W'(1);
          end else if (out_ready) begin
            wv        <= wv_drop;
            spk_count <= spk_count + CNT_W'(1);
            if (single_left) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registers only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == SCAN) && nz;
  assign out_last  = out_valid && single_left;
  assign out_addr  = out_valid ? ADDR_W'({idx, pos}) : '0;

endmodule

// File: tb/tb_spk_addr_serializer.sv
module tb_spk_addr_serializer;

  localparam int unsigned N_IN   = 64;
  localparam int unsigned CHUNK  = 32;
  localparam int unsigned ADDR_W = $clog2(N_IN);
  localparam int unsigned CNT_W  = $clog2(N_IN + 1);
  localparam int          BUDGET = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   spk_vec;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  spk_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spk_addr_serializer #(.N_IN(N_IN), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .spk_vec   (spk_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .spk_count (spk_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N_IN-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  // Runs one frame. Reference: the expected addresses are the set bits in
  // ascending order; the j-th one (chunk k) is first shown at cycle
  // 1 + k + j + (cycles the consumer stalled so far). ready_mode 0 holds
  // out_ready low for the first stall_n cycles then high; 1 is random.
  task automatic run_frame(input logic [N_IN-1:0] vec, input int ready_mode, input int stall_n);
    int q[$];
    int n, acc, stalls, last_acc_t, t;
    bit finished;
    for (int i = 0; i < N_IN; i++) if (vec[i]) q.push_back(i);
    n = q.size();
    acc = 0; stalls = 0; last_acc_t = -1; finished = 0;

    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    in_valid = 1'b1;
    spk_vec  = vec;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    spk_vec  = rand_vec();
    t = 1;
    while (!finished && t <= BUDGET) begin
      out_ready = (ready_mode == 0) ? (t > stall_n) : ($urandom_range(0, 9) < 7);
      @(negedge clk);
      check("busy", busy, 1);
      check("in_ready", in_ready, 0);
      check("count_mid", spk_count, acc);
      check("valid", out_valid,
            (q.size() > 0) && (t >= 1 + q[0] / CHUNK + acc + stalls));
      if (out_valid && q.size() > 0) begin
        check("addr", out_addr, q[0]);
        check("last", out_last, q.size() == 1);
      end
      check("done", done, (q.size() == 0) && ((n == 0) ? (t == 1) : (t == last_acc_t + 1)));
      if (done) begin
        check("count_final", spk_count, n);
        finished = 1;
      end else if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        acc++;
        last_acc_t = t;
      end else if (out_valid) begin
        stalls++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!finished) check("timeout", 1, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N_IN-1:0] v;
    rst = 1'b1; in_valid = 1'b0; spk_vec = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", spk_count, 0);
    rst = 1'b0;

    // Two spikes in different chunks, one bubble between them.
    v = '0; v[3] = 1'b1; v[40] = 1'b1;
    run_frame(v, 0, 0);
    // Empty frame.
    run_frame('0, 0, 0);
    // Backpressure on the first address.
    v = '0; v[0] = 1'b1; v[1] = 1'b1;
    run_frame(v, 0, 3);
    // Dense frame.
    run_frame('1, 0, 0);
    // Spike only at the top bit, behind an empty chunk.
    v = '0; v[N_IN-1] = 1'b1;
    run_frame(v, 0, 0);

    // Reset mid-frame after the first address is accepted.
    v = '0; v[5] = 1'b1; v[6] = 1'b1; v[7] = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; spk_vec = v; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_addr5", out_addr, 5);
    check("mr_valid5", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_count", spk_count, 0);
    check("mr_done", done, 0);
    check("mr_busy", busy, 0);
    v = '0; v[9] = 1'b1;
    run_frame(v, 0, 0);

    // Random frames of varying density with random backpressure.
    for (int f = 0; f < 24; f++) begin
      case (f % 4)
        0: v = rand_vec();
        1: v = rand_vec() & rand_vec() & rand_vec();
        2: v = {rand_vec() & rand_vec(), 32'h0} >> 32 << ((f & 4) != 0 ? 32 : 0);
        default: v = ($urandom_range(0, 1) == 1) ? '0 : (N_IN'(1) << $urandom_range(0, N_IN - 1));
      endcase
      run_frame(v, (f % 3 == 0) ? 0 : 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
